// File: rtl/mem_stream_fifo_if.sv
// mem_stream_fifo_if: stream handshakes and memory port bundle for mem_stream_fifo; MEM_STREAM_FIFO_FLAGS_EN adds flag signals
interface mem_stream_fifo_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int LVL_W  = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] mem_write_data;
    logic [ADDR_W-1:0] mem_write_address;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_read_address;
    logic [DATA_W-1:0] mem_read_data;
    logic [LVL_W-1:0]  level;
`ifdef MEM_STREAM_FIFO_FLAGS_EN
    logic almost_full;
    logic overflow_err;
    modport slave (
        input  in_data, in_valid, out_ready, mem_read_data,
        output in_ready, out_data, out_valid, mem_write_data, mem_write_address,
               mem_we, mem_read_address, level, almost_full, overflow_err
    );
    modport master (
        output in_data, in_valid, out_ready, mem_read_data,
        input  in_ready, out_data, out_valid, mem_write_data, mem_write_address,
               mem_we, mem_read_address, level, almost_full, overflow_err
    );
`else
    modport slave (
        input  in_data, in_valid, out_ready, mem_read_data,
        output in_ready, out_data, out_valid, mem_write_data, mem_write_address,
               mem_we, mem_read_address, level
    );
    modport master (
        output in_data, in_valid, out_ready, mem_read_data,
        input  in_ready, out_data, out_valid, mem_write_data, mem_write_address,
               mem_we, mem_read_address, level
    );
`endif
endinterface

// File: rtl/mem_stream_fifo.sv
// mem_stream_fifo: streaming FIFO controller over a 1-cycle-latency synchronous memory; MEM_STREAM_FIFO_FLAGS_EN adds almost_full/overflow_err
module mem_stream_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 128,
    parameter int PTR_W     = 7,
    parameter int ADDR_W    = 16,
    parameter int LVL_W     = 8,
    parameter int AF_THRESH = 120
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_stream_fifo_if.slave  bus
);
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_mem_cnt;
    logic              r_inflight;
    logic [1:0]        r_buf_cnt;
    logic              r_head;
    logic              r_tail;
    logic [DATA_W-1:0] r_buf [2];
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic [PTR_W:0]    w_mem_cnt_nxt;
    logic [1:0]        w_buf_cnt_nxt;

    assign bus.in_ready          = r_mem_cnt < (PTR_W+1)'(DEPTH);
    assign bus.out_valid         = r_buf_cnt != 2'd0;
    assign bus.out_data          = r_buf[r_head];
    assign w_push                = bus.in_valid & bus.in_ready;
    assign w_pop                 = bus.out_valid & bus.out_ready;
    // registered mem_cnt means a word written this cycle is never read this cycle
    assign w_issue               = (r_mem_cnt != '0) &
                                   (({1'b0, r_buf_cnt} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));
    assign w_mem_cnt_nxt         = r_mem_cnt + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_issue);
    assign w_buf_cnt_nxt         = r_buf_cnt + 2'(r_inflight) - 2'(w_pop);
    assign bus.mem_write_data    = bus.in_data;
    assign bus.mem_write_address = ADDR_W'(r_wr_ptr);
    assign bus.mem_we            = w_push;
    assign bus.mem_read_address  = ADDR_W'(r_rd_ptr);
    assign bus.level             = LVL_W'(r_mem_cnt) + LVL_W'(r_inflight) + LVL_W'(r_buf_cnt);

    // pointers, occupancy counters and the 2-entry skid buffer that absorbs read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
            r_buf_cnt  <= 2'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr   <= r_rd_ptr + PTR_W'(w_issue);
            r_mem_cnt  <= w_mem_cnt_nxt;
            r_inflight <= w_issue;
            r_buf_cnt  <= w_buf_cnt_nxt;
            r_head     <= r_head ^ w_pop;
            r_tail     <= r_tail ^ r_inflight;
            if (r_inflight) r_buf[r_tail] <= bus.mem_read_data;
        end
    end

`ifdef MEM_STREAM_FIFO_FLAGS_EN
    logic [LVL_W-1:0] w_level_nxt;
    logic             w_stall;
    logic [4:0]       r_stall_cnt;
    logic             r_af;
    logic             r_ovf;

    assign w_level_nxt      = LVL_W'(w_mem_cnt_nxt) + LVL_W'(w_issue) + LVL_W'(w_buf_cnt_nxt);
    assign w_stall          = bus.in_valid & ~bus.in_ready;
    assign bus.almost_full  = r_af;
    assign bus.overflow_err = r_ovf;

    // almost_full from next-state level; sticky error once the producer stalls more than 16 cycles in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_af        <= 1'b0;
            r_ovf       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_af        <= w_level_nxt >= LVL_W'(AF_THRESH);
            r_stall_cnt <= w_stall ? r_stall_cnt + 5'(r_stall_cnt != 5'd31) : '0;
            r_ovf       <= r_ovf | (w_stall & (r_stall_cnt >= 5'd16));
        end
    end
`endif
endmodule

// File: tb/tb_mem_stream_fifo.sv
// tb_mem_stream_fifo: randomized scoreboard bench for mem_stream_fifo with an attached 128x32 memory model
module tb_mem_stream_fifo;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passes = 0;
    int   total = 0;

    mem_stream_fifo_if #(.DATA_W(32), .ADDR_W(16), .LVL_W(8)) bus ();
    mem_stream_fifo dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    logic [31:0] q [$];
    int          stall_run = 0;
    logic        ovf_exp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // the external synchronous memory: registered read returning old data on read-during-write
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_write_address[6:0]] <= bus.mem_write_data;
        bus.mem_read_data <= mem[bus.mem_read_address[6:0]];
    end

    // compare DUT against the queue model, then apply this cycle's handshakes to the model
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stall_run = 0;
            ovf_exp = 1'b0;
        end else begin
            chk("level", 64'(bus.level), 64'(q.size()));
            if (q.size() == 0) chk("valid_when_empty", 64'(bus.out_valid), 64'd0);
            if (bus.out_valid && q.size() != 0) chk("head_data", 64'(bus.out_data), 64'(q[0]));
            if (q.size() < DEPTH) chk("ready_below_depth", 64'(bus.in_ready), 64'd1);
            if (q.size() >= DEPTH + 2) chk("ready_at_max", 64'(bus.in_ready), 64'd0);
            chk("mem_we", 64'(bus.mem_we), 64'(bus.in_valid && bus.in_ready));
            if (bus.mem_we) chk("mem_wdata", 64'(bus.mem_write_data), 64'(bus.in_data));
`ifdef MEM_STREAM_FIFO_FLAGS_EN
            chk("almost_full", 64'(bus.almost_full), 64'(q.size() >= 120));
            chk("overflow_err", 64'(bus.overflow_err), 64'(ovf_exp));
            stall_run = (bus.in_valid && !bus.in_ready) ? stall_run + 1 : 0;
            if (stall_run > 16) ovf_exp = 1'b1;
`endif
            if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
            if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   k;
        int   got;
        int   acc;
        logic started;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_level", 64'(bus.level), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        bus.in_data = 32'hA5A5_0001;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("lat_mem_we", 64'(bus.mem_we), 64'd1);
        chk("lat_waddr", 64'(bus.mem_write_address), 64'd0);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_valid_e1", 64'(bus.out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("lat_valid_e2", 64'(bus.out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("lat_valid_e3", 64'(bus.out_valid), 64'd1);
        chk("lat_data_e3", 64'(bus.out_data), 64'hA5A5_0001);
        step();
        @(negedge clk);
        chk("lat_level_after_pop", 64'(bus.level), 64'd0);
        step();
        k = 0;
        got = 0;
        started = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 32'd0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 400 && got < 200; c++) begin
            @(negedge clk);
            acc = int'(bus.in_valid && bus.in_ready);
            if (bus.out_valid) started = 1'b1;
            if (started) begin
                chk("stream_no_bubble", 64'(bus.out_valid), 64'd1);
                if (bus.out_valid) begin
                    chk("stream_data", 64'(bus.out_data), 64'(got));
                    got++;
                end
            end
            step();
            k += acc;
            bus.in_valid = k < 200;
            bus.in_data = 32'(k);
        end
        chk("stream_count", 64'(got), 64'd200);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
        k = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            bus.in_data = $urandom;
            @(negedge clk);
`ifdef MEM_STREAM_FIFO_FLAGS_EN
            if (bus.level == 8'd119) chk("af_at_119", 64'(bus.almost_full), 64'd0);
            if (bus.level == 8'd120) chk("af_at_120", 64'(bus.almost_full), 64'd1);
`endif
            if (!bus.in_ready) break;
            k++;
            step();
        end
        chk("fill_accepted", 64'(k), 64'd130);
        chk("fill_level", 64'(bus.level), 64'd130);
        chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
`ifdef MEM_STREAM_FIFO_FLAGS_EN
        chk("ovf_not_yet", 64'(bus.overflow_err), 64'd0);
        repeat (20) step();
        @(negedge clk);
        chk("ovf_set", 64'(bus.overflow_err), 64'd1);
`endif
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("pop_ready_before", 64'(bus.in_ready), 64'd0);
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("pop_ready_after", 64'(bus.in_ready), 64'd1);
        chk("pop_level_after", 64'(bus.level), 64'd129);
        for (int c = 0; c < 5000; c++) begin
            step();
            bus.out_ready = c[0];
            bus.in_valid = ($urandom % 5) < 2;
            bus.in_data = $urandom;
        end
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 400 && bus.level != 0; c++) step();
        @(negedge clk);
        chk("drain_level", 64'(bus.level), 64'd0);
        step();
        bus.in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.in_data = 32'hDEAD_0000 | 32'(c);
            step();
        end
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_level", 64'(bus.level), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef MEM_STREAM_FIFO_FLAGS_EN
        chk("mid_rst_ovf", 64'(bus.overflow_err), 64'd0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();
        bus.in_valid = 1'b1;
        bus.in_data = 32'h1;
        step();
        bus.in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk("post_rst_data", 64'(bus.out_data), 64'h1);
                got++;
            end
            step();
        end
        chk("post_rst_count", 64'(got), 64'd1);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
